// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: resolves memory freezes, taken-branch flushes,
// multi-cycle multiply occupancy and load-use stalls; counts stalls and flushes.
module hazard_sequencer #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  IFID_Rs,
    input  logic [4:0]  IFID_Rt,
    input  logic        IFID_UsesRt,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_Rt,
    input  logic        IDEX_IsMul,
    input  logic        BranchTaken,
    input  logic        EXMEM_MemAccess,
    input  logic        DmemReady,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IDEXWrite,
    output logic        EXMEMWrite,
    output logic        IFIDFlush,
    output logic        IDEXBubble,
    output logic        EXMEMBubble,
    output logic        MEMWBBubble,
    output logic [15:0] StallCycles,
    output logic [15:0] FlushCount
);

    typedef enum logic {RUN, MULWAIT} state_e;

    state_e      state_q, state_d;
    logic [3:0]  mul_cnt_q, mul_cnt_d;
    logic [15:0] stall_q, flush_q;
    logic        flush_inc;
    logic        mem_stall, load_use;

    assign mem_stall = EXMEM_MemAccess & ~DmemReady;
    assign load_use  = IDEX_MemRead & (IDEX_Rt != 5'd0) &
                       ((IDEX_Rt == IFID_Rs) | (IFID_UsesRt & (IDEX_Rt == IFID_Rt)));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= RUN;
            mul_cnt_q <= 4'd0;
            stall_q   <= 16'd0;
            flush_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            if (!PCWrite && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
            if (flush_inc && flush_q != 16'hFFFF)
                flush_q <= flush_q + 16'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        mul_cnt_d   = mul_cnt_q;
        flush_inc   = 1'b0;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEXWrite   = 1'b1;
        EXMEMWrite  = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXBubble  = 1'b0;
        EXMEMBubble = 1'b0;
        MEMWBBubble = 1'b0;

        if (Reset) begin
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXWrite   = 1'b0;
            EXMEMWrite  = 1'b0;
            IFIDFlush   = 1'b1;
            IDEXBubble  = 1'b1;
            EXMEMBubble = 1'b1;
            MEMWBBubble = 1'b1;
        end else if (mem_stall) begin
            // Freeze everything up to MEM; MulCnt and state hold in both states
            PCWrite     = 1'b0;
            IFIDWrite   = 1'b0;
            IDEXWrite   = 1'b0;
            EXMEMWrite  = 1'b0;
            MEMWBBubble = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (BranchTaken) begin
                        IFIDFlush  = 1'b1;
                        IDEXBubble = 1'b1;
                        flush_inc  = 1'b1;
                    end else if (IDEX_IsMul) begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEXWrite   = 1'b0;
                        EXMEMBubble = 1'b1;
                        state_d     = MULWAIT;
                        mul_cnt_d   = 4'(MUL_CYCLES - 2);
                    end else if (load_use) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXBubble = 1'b1;
                    end
                end
                MULWAIT: begin
                    if (mul_cnt_q != 4'd0) begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEXWrite   = 1'b0;
                        EXMEMBubble = 1'b1;
                        mul_cnt_d   = mul_cnt_q - 4'd1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign StallCycles = stall_q;
    assign FlushCount  = flush_q;

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, total EX-stage occupancy of a multiply, legal range 2..15.
REQ-002 SHALL have port Clk  in  1  clock; all state SHALL update on the rising edge.
REQ-003 SHALL have port Reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port IFID_Rs  in  5  rs field of the instruction in ID.
REQ-005 SHALL have port IFID_Rt  in  5  rt field of the instruction in ID.
REQ-006 SHALL have port IFID_UsesRt  in  1  ID instruction reads rt as a source.
REQ-007 SHALL have port IDEX_MemRead  in  1  instruction in EX is a load.
REQ-008 SHALL have port IDEX_Rt  in  5  load destination register in EX.
REQ-009 SHALL have port IDEX_IsMul  in  1  instruction in EX is a multiply.
REQ-010 SHALL have port BranchTaken  in  1  branch resolved taken in EX this cycle.
REQ-011 SHALL have port EXMEM_MemAccess  in  1  MEM-stage instruction accesses data memory.
REQ-012 SHALL have port DmemReady  in  1  data memory completes the access this cycle.
REQ-013 SHALL have ports PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite  out  1 each  load enables of PC and pipeline registers.
REQ-014 SHALL have ports IFIDFlush, IDEXBubble, EXMEMBubble, MEMWBBubble  out  1 each  force the named register to a NOP/zero-control value on its next load.
REQ-015 SHALL have port StallCycles  out  16  saturating count of cycles with PCWrite=0.
REQ-016 SHALL have port FlushCount  out  16  saturating count of taken-branch flushes.

Function
REQ-017 SHALL implement a two-state FSM: RUN and MULWAIT, plus a 4-bit down counter MulCnt.
REQ-018 SHALL define MemStall = EXMEM_MemAccess & ~DmemReady; LoadUse = IDEX_MemRead & (IDEX_Rt!=0) & ((IDEX_Rt==IFID_Rs) | (IFID_UsesRt & IDEX_Rt==IFID_Rt)).
REQ-019 SHALL drive all control outputs combinationally from current state and inputs, with zero-cycle latency.
REQ-020 Default ("advance") outputs SHALL be: all four enables=1, IFIDFlush and all bubbles=0.
REQ-021 In RUN, with priority MemStall > BranchTaken > IDEX_IsMul > LoadUse > advance, the block SHALL act as follows.
REQ-022 MemStall (freeze): PCWrite=IFIDWrite=IDEXWrite=EXMEMWrite=0, MEMWBBubble=1, other bubbles=0; state unchanged.
REQ-023 BranchTaken: enables=1, IFIDFlush=1, IDEXBubble=1, EXMEMBubble=0; FlushCount increments.
REQ-024 IDEX_IsMul (entry): PCWrite=IFIDWrite=IDEXWrite=0, EXMEMWrite=1, EXMEMBubble=1; next state MULWAIT, MulCnt<=MUL_CYCLES-2.
REQ-025 LoadUse: PCWrite=IFIDWrite=0, IDEXWrite=1, IDEXBubble=1, EXMEMWrite=1; exactly one stall cycle per load.
REQ-026 In MULWAIT with MemStall: freeze outputs as REQ-022; MulCnt and state SHALL hold.
REQ-027 In MULWAIT, no MemStall, MulCnt!=0: stall outputs as REQ-024; MulCnt decrements.
REQ-028 In MULWAIT, no MemStall, MulCnt==0: advance outputs; next state RUN.
REQ-029 In MULWAIT, BranchTaken and LoadUse SHALL be ignored.
REQ-030 A multiply SHALL therefore produce exactly MUL_CYCLES-1 stall cycles plus one release cycle, excluding freeze cycles.
REQ-031 Back-to-back multiplies SHALL each re-enter MULWAIT from RUN on the cycle after release.
REQ-032 StallCycles SHALL increment every non-reset cycle with PCWrite=0 and SHALL saturate at 16'hFFFF.
REQ-033 FlushCount SHALL saturate at 16'hFFFF.

Reset
REQ-034 On a clock edge with Reset=1: state<=RUN, MulCnt<=0, StallCycles<=0, FlushCount<=0.
REQ-035 While Reset=1: all enables=0, IFIDFlush and all bubbles=1, counters do not increment.
REQ-036 Reset asserted in MULWAIT SHALL abort the multiply stall and return the FSM to RUN.

Verification
REQ-037 Load r5 in EX, ID reads rs=5 -> one cycle PCWrite=0, IDEXBubble=1, then advance; StallCycles=1.
REQ-038 Load with IDEX_Rt=0 matching IFID_Rs=0 -> no stall.
REQ-039 IDEX_IsMul=1, MUL_CYCLES=4 -> 3 stall cycles with EXMEMBubble=1, 4th cycle advance, state RUN; StallCycles=3.
REQ-040 Mul stall with DmemReady=0 for 2 cycles mid-wait -> freeze 2 cycles, MulCnt held; total PCWrite=0 cycles=5.
REQ-041 BranchTaken and LoadUse together -> IFIDFlush=1, IDEXBubble=1, PCWrite=1; FlushCount=1, StallCycles=0.
REQ-042 Reset in second MULWAIT cycle -> next cycle state RUN, counters 0, advance outputs.
